// File: rtl/fetch_stage.sv
// Instruction-fetch stage with IF/ID pipeline register.
// Keeps one request outstanding to a variable-latency instruction memory.
// Holds the fetch on StallD and redirects it on a taken branch from execute.
// Drives a NOP bubble into decode whenever no instruction is available, or on FlushD.
//
// Memory handshake: while imem_req is high, imem_addr is held stable.
// The request completes in the cycle in which imem_valid pulses high, and
// imem_rdata is sampled in that same cycle. Zero-wait responses are allowed.
// A request cannot be withdrawn, so a redirect that lands while a request is
// in flight waits in DRAIN for the stale response and then discards it.
module fetch_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        StallD,
    input  logic        FlushD,
    input  logic        PCSrcE,
    input  logic [31:0] PCTargetE,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_valid,
    input  logic [31:0] imem_rdata,
    output logic [31:0] InstrD,
    output logic [31:0] PCD,
    output logic [31:0] PCPlus4D,
    output logic        ValidD,
    output logic        FetchBusyF,
    output logic [1:0]  state_dbg_o
);

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        HELD  = 2'd1,
        DRAIN = 2'd2
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] pcf_q, pcf_d;
    logic [31:0] req_addr_q, req_addr_d;
    logic [31:0] buf_q, buf_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] pcd_q, pcd_d;
    logic [31:0] pcplus4_q, pcplus4_d;
    logic        valid_q, valid_d;

    logic        avail;
    logic [31:0] avail_instr;
    logic [31:0] pcf_plus4;

    assign pcf_plus4 = pcf_q + 32'd4;

    // Fetch-side registers: PC, request address, FSM state and the holding buffer.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= FETCH;
            pcf_q      <= RESET_PC;
            req_addr_q <= RESET_PC;
            buf_q      <= NOP_INSTR;
        end else begin
            state_q    <= state_d;
            pcf_q      <= pcf_d;
            req_addr_q <= req_addr_d;
            buf_q      <= buf_d;
        end
    end

    // Fetch FSM next state. A redirect takes priority over a stall.
    always_comb begin
        state_d    = state_q;
        pcf_d      = pcf_q;
        req_addr_d = req_addr_q;
        buf_d      = buf_q;
        unique case (state_q)
            FETCH: begin
                if (PCSrcE) begin
                    pcf_d = PCTargetE;
                    if (imem_valid) begin
                        req_addr_d = PCTargetE;
                    end else begin
                        state_d = DRAIN;
                    end
                end else if (imem_valid) begin
                    if (StallD) begin
                        buf_d   = imem_rdata;
                        state_d = HELD;
                    end else begin
                        pcf_d      = pcf_plus4;
                        req_addr_d = pcf_plus4;
                    end
                end
            end
            HELD: begin
                if (PCSrcE) begin
                    pcf_d      = PCTargetE;
                    req_addr_d = PCTargetE;
                    state_d    = FETCH;
                end else if (!StallD) begin
                    pcf_d      = pcf_plus4;
                    req_addr_d = pcf_plus4;
                    state_d    = FETCH;
                end
            end
            DRAIN: begin
                if (PCSrcE) begin
                    pcf_d = PCTargetE;
                end
                // When the stale response arrives, restart at the current PC,
                // or at a target that is redirecting in this same cycle.
                if (imem_valid) begin
                    req_addr_d = PCSrcE ? PCTargetE : pcf_q;
                    state_d    = FETCH;
                end
            end
            default: begin
                state_d = FETCH;
            end
        endcase
    end

    // Instruction available to decode this cycle. A redirect kills any candidate word.
    always_comb begin
        avail       = 1'b0;
        avail_instr = NOP_INSTR;
        if (!PCSrcE) begin
            if (state_q == FETCH && imem_valid) begin
                avail       = 1'b1;
                avail_instr = imem_rdata;
            end else if (state_q == HELD) begin
                avail       = 1'b1;
                avail_instr = buf_q;
            end
        end
    end

    // IF/ID next value. Priority order: flush, then stall, then load, else bubble.
    always_comb begin
        instr_d   = instr_q;
        pcd_d     = pcd_q;
        pcplus4_d = pcplus4_q;
        valid_d   = valid_q;
        if (FlushD) begin
            instr_d   = NOP_INSTR;
            pcd_d     = 32'd0;
            pcplus4_d = 32'd0;
            valid_d   = 1'b0;
        end else if (!StallD) begin
            if (avail) begin
                instr_d   = avail_instr;
                pcd_d     = pcf_q;
                pcplus4_d = pcf_plus4;
                valid_d   = 1'b1;
            end else begin
                instr_d   = NOP_INSTR;
                pcd_d     = 32'd0;
                pcplus4_d = 32'd0;
                valid_d   = 1'b0;
            end
        end
    end

    // IF/ID pipeline register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            instr_q   <= NOP_INSTR;
            pcd_q     <= 32'd0;
            pcplus4_q <= 32'd0;
            valid_q   <= 1'b0;
        end else begin
            instr_q   <= instr_d;
            pcd_q     <= pcd_d;
            pcplus4_q <= pcplus4_d;
            valid_q   <= valid_d;
        end
    end

    // The request is gated by rst so that it drops at once while reset is held.
    assign imem_req    = !rst && (state_q != HELD);
    assign imem_addr   = req_addr_q;
    assign FetchBusyF  = (state_q == DRAIN) || (state_q == FETCH && !imem_valid);
    assign InstrD      = instr_q;
    assign PCD         = pcd_q;
    assign PCPlus4D    = pcplus4_q;
    assign ValidD      = valid_q;
    assign state_dbg_o = state_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage. Each step drives the inputs just after a rising edge.
// Combinational outputs are checked on the falling edge.
// Registered outputs are checked just after the following rising edge.
module tb_fetch_stage;

    localparam logic [31:0] NOP = 32'h0000_0013;
    localparam logic [1:0]  S_FETCH = 2'd0;
    localparam logic [1:0]  S_HELD  = 2'd1;
    localparam logic [1:0]  S_DRAIN = 2'd2;

    logic        clk = 1'b0;
    logic        rst;
    logic        StallD, FlushD, PCSrcE;
    logic [31:0] PCTargetE;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_valid;
    logic [31:0] imem_rdata;
    logic [31:0] InstrD, PCD, PCPlus4D;
    logic        ValidD, FetchBusyF;
    logic [1:0]  state_dbg;

    int n_checks = 0;
    int n_errors = 0;

    fetch_stage dut (
        .clk        (clk),
        .rst        (rst),
        .StallD     (StallD),
        .FlushD     (FlushD),
        .PCSrcE     (PCSrcE),
        .PCTargetE  (PCTargetE),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_valid (imem_valid),
        .imem_rdata (imem_rdata),
        .InstrD     (InstrD),
        .PCD        (PCD),
        .PCPlus4D   (PCPlus4D),
        .ValidD     (ValidD),
        .FetchBusyF (FetchBusyF),
        .state_dbg_o(state_dbg)
    );

    // Clock generation.
    always #5 clk = ~clk;

    // Single comparison point for every check in the bench.
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Drive every input for one cycle.
    task automatic drive(input logic stall, input logic flush, input logic pcsrc,
                         input logic [31:0] target, input logic valid, input logic [31:0] rdata);
        StallD     = stall;
        FlushD     = flush;
        PCSrcE     = pcsrc;
        PCTargetE  = target;
        imem_valid = valid;
        imem_rdata = rdata;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_ifid(input string tag, input logic [31:0] instr, input logic [31:0] pc,
                              input logic [31:0] pc4, input logic valid);
        check({tag, "_instr"}, InstrD, instr);
        check({tag, "_pcd"}, PCD, pc);
        check({tag, "_pc4"}, PCPlus4D, pc4);
        check({tag, "_valid"}, {31'd0, ValidD}, {31'd0, valid});
    endtask

    initial begin
        rst = 1'b1;
        drive(0, 0, 0, 32'h0, 0, 32'h0);
        tick();
        tick();
        @(negedge clk);
        check("rst_req", {31'd0, imem_req}, 32'd0);
        check("rst_addr", imem_addr, 32'h0);
        check("rst_state", {30'd0, state_dbg}, {30'd0, S_FETCH});
        check_ifid("rst", NOP, 32'h0, 32'h0, 1'b0);

        // Release reset. The memory answers at addr 0 with zero wait.
        tick();
        rst = 1'b0;
        drive(0, 0, 0, 32'h0, 1, 32'h0050_0093);
        @(negedge clk);
        check("a_req", {31'd0, imem_req}, 32'd1);
        check("a_addr", imem_addr, 32'h0);
        check("a_busy", {31'd0, FetchBusyF}, 32'd0);
        tick();
        check_ifid("a", 32'h0050_0093, 32'h0, 32'h4, 1'b1);
        check("a_next_addr", imem_addr, 32'h4);

        // Three wait cycles on the fetch from 4: decode sees bubbles meanwhile.
        for (int i = 0; i < 3; i++) begin
            drive(0, 0, 0, 32'h0, 0, 32'h0);
            @(negedge clk);
            check("b_busy", {31'd0, FetchBusyF}, 32'd1);
            check("b_addr", imem_addr, 32'h4);
            check("b_req", {31'd0, imem_req}, 32'd1);
            tick();
            check_ifid("b_bubble", NOP, 32'h0, 32'h0, 1'b0);
        end
        drive(0, 0, 0, 32'h0, 1, 32'h00A0_0113);
        tick();
        check_ifid("b", 32'h00A0_0113, 32'h4, 32'h8, 1'b1);
        check("b_next_addr", imem_addr, 32'h8);

        // The word at 8 returns while StallD is high, then stall holds a second cycle.
        drive(1, 0, 0, 32'h0, 1, 32'h0020_8193);
        @(negedge clk);
        check("c_busy", {31'd0, FetchBusyF}, 32'd0);
        tick();
        check("c_state", {30'd0, state_dbg}, {30'd0, S_HELD});
        check("c_req", {31'd0, imem_req}, 32'd0);
        check_ifid("c_hold1", 32'h00A0_0113, 32'h4, 32'h8, 1'b1);
        drive(1, 0, 0, 32'h0, 0, 32'h0);
        @(negedge clk);
        check("c_busy_held", {31'd0, FetchBusyF}, 32'd0);
        tick();
        check("c_req2", {31'd0, imem_req}, 32'd0);
        check_ifid("c_hold2", 32'h00A0_0113, 32'h4, 32'h8, 1'b1);
        drive(0, 0, 0, 32'h0, 0, 32'h0);
        tick();
        check_ifid("c", 32'h0020_8193, 32'h8, 32'hC, 1'b1);
        check("c_next_addr", imem_addr, 32'hC);
        check("c_req3", {31'd0, imem_req}, 32'd1);

        // A redirect to 0x100 arrives while the fetch from 12 is still pending.
        drive(0, 0, 1, 32'h100, 0, 32'h0);
        tick();
        check("d_state", {30'd0, state_dbg}, {30'd0, S_DRAIN});
        check("d_addr_stale", imem_addr, 32'hC);
        check("d_valid", {31'd0, ValidD}, 32'd0);
        drive(0, 0, 0, 32'h0, 1, 32'hDEAD_BEEF);
        @(negedge clk);
        check("d_busy", {31'd0, FetchBusyF}, 32'd1);
        check("d_req", {31'd0, imem_req}, 32'd1);
        tick();
        check_ifid("d_discard", NOP, 32'h0, 32'h0, 1'b0);
        check("d_new_addr", imem_addr, 32'h100);
        drive(0, 0, 0, 32'h0, 1, 32'h0040_0213);
        tick();
        check_ifid("d", 32'h0040_0213, 32'h100, 32'h104, 1'b1);

        // FlushD and StallD together: IF/ID flushes while the fetch holds at 0x104.
        drive(1, 1, 0, 32'h0, 0, 32'h0);
        tick();
        check_ifid("e_flush", NOP, 32'h0, 32'h0, 1'b0);
        check("e_addr", imem_addr, 32'h104);
        drive(1, 0, 0, 32'h0, 1, 32'h1234_5678);
        tick();
        check("e_state", {30'd0, state_dbg}, {30'd0, S_HELD});
        check_ifid("e_hold", NOP, 32'h0, 32'h0, 1'b0);
        drive(0, 0, 0, 32'h0, 0, 32'h0);
        tick();
        check_ifid("e", 32'h1234_5678, 32'h104, 32'h108, 1'b1);

        // Redirect to the top of memory while a response lands; the word is discarded.
        drive(0, 0, 1, 32'hFFFF_FFFC, 1, 32'hBAD0_BAD0);
        tick();
        check("f_state", {30'd0, state_dbg}, {30'd0, S_FETCH});
        check("f_addr", imem_addr, 32'hFFFF_FFFC);
        check("f_valid", {31'd0, ValidD}, 32'd0);
        drive(0, 0, 0, 32'h0, 1, 32'h0000_006F);
        tick();
        check_ifid("f", 32'h0000_006F, 32'hFFFF_FFFC, 32'h0, 1'b1);
        check("f_wrap_addr", imem_addr, 32'h0);

        // Assert reset in mid-request; outputs must clear without any clock edge.
        drive(0, 0, 0, 32'h0, 0, 32'h0);
        @(negedge clk);
        check("g_req_pre", {31'd0, imem_req}, 32'd1);
        #2;
        rst = 1'b1;
        #1;
        check("g_req", {31'd0, imem_req}, 32'd0);
        check("g_valid", {31'd0, ValidD}, 32'd0);
        check("g_instr", InstrD, NOP);
        tick();
        rst = 1'b0;
        @(negedge clk);
        check("g_req_after", {31'd0, imem_req}, 32'd1);
        check("g_addr_after", imem_addr, 32'h0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
